// File: rtl/cl_pcis_mem_bridge.sv
// cl_pcis_mem_bridge
//   AXI4 slave terminating the registered dma_pcis path. INCR write and read
//   bursts become single-beat accesses on a simple synchronous memory port
//   (read data returns one cycle after mem_re). One burst at a time; AW/AR
//   are arbitrated per burst, alternating on a tie (write wins first).
//
//   Optional feature macro: PCIS_BRIDGE_ERR_EN
//     defined   : bursts running past the last word are suppressed and answered
//                 with SLVERR; a misplaced wlast gives bresp = SLVERR.
//     undefined : addresses wrap, wlast is ignored, responses are always OKAY.
//
//   Ports
//     aclk, aresetn        clock, async active-low reset
//     s_axi_aw*/w*/b*      AXI4 write address / data / response channels
//     s_axi_ar*/r*         AXI4 read address / data channels
//     mem_we, mem_re       memory write / read strobes (never both)
//     mem_addr             memory word address
//     mem_wdata, mem_be    write data and byte enables (wdata / wstrb)
//     mem_rdata            read data, valid the cycle after mem_re
module cl_pcis_mem_bridge #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 6,
  parameter int MEM_AW     = 10,
  parameter int ADDR_LSB   = 6
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // write address
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [63:0]             s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [63:0]             s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // memory port
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

`ifdef PCIS_BRIDGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WR, WR_RESP, RD} state_t;

  state_t                  state_q, state_d;
  logic                    en_q;          // low for the first cycle out of reset
  logic                    last_rd_q;     // last granted burst was a read
  logic [ID_WIDTH-1:0]     id_q;
  logic [7:0]              wlen_q;        // write beats remaining minus one
  logic [8:0]              iss_left_q;    // read beats still to be issued
  logic [MEM_AW-1:0]       addr_q;
  logic                    err_q;         // burst runs past the last word
  logic                    wl_err_q;      // wlast misplaced in this write burst
  logic                    inflight_q;
  logic                    inflight_last_q;

  logic [DATA_WIDTH-1:0]   fifo_data [2];
  logic                    fifo_last [2];
  logic                    fifo_err  [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              cnt_q;

  logic                    grant_wr, grant_rd, w_hs, pop, push, rd_issue;
  logic [2:0]              occ;
  logic [MEM_AW-1:0]       aw_word, ar_word;
  logic                    unused_bits;

  assign unused_bits = ^{s_axi_awsize, s_axi_arsize,
                         s_axi_awaddr[63:ADDR_LSB+MEM_AW], s_axi_awaddr[ADDR_LSB-1:0],
                         s_axi_araddr[63:ADDR_LSB+MEM_AW], s_axi_araddr[ADDR_LSB-1:0]};

  assign aw_word = s_axi_awaddr[ADDR_LSB +: MEM_AW];
  assign ar_word = s_axi_araddr[ADDR_LSB +: MEM_AW];

  function automatic logic over_end(input logic [MEM_AW-1:0] start, input logic [7:0] len);
    logic [MEM_AW+8:0] last_word;
    last_word = (MEM_AW+9)'(start) + (MEM_AW+9)'(len);
    return last_word > (MEM_AW+9)'({MEM_AW{1'b1}});
  endfunction

  // Tie between AW and AR goes to the type not granted last time.
  assign grant_wr = (state_q == IDLE) && en_q && s_axi_awvalid && (!s_axi_arvalid || last_rd_q);
  assign grant_rd = (state_q == IDLE) && en_q && s_axi_arvalid && (!s_axi_awvalid || !last_rd_q);

  assign s_axi_awready = grant_wr;
  assign s_axi_arready = grant_rd;

  assign s_axi_wready = (state_q == WR);
  assign w_hs         = s_axi_wvalid && s_axi_wready;

  assign s_axi_bvalid = (state_q == WR_RESP);
  assign s_axi_bid    = id_q;
  assign s_axi_bresp  = {err_q | wl_err_q, 1'b0};

  assign s_axi_rvalid = (cnt_q != 2'd0);
  assign s_axi_rid    = id_q;
  assign s_axi_rdata  = fifo_data[rd_ptr_q];
  assign s_axi_rlast  = fifo_last[rd_ptr_q];
  assign s_axi_rresp  = {fifo_err[rd_ptr_q], 1'b0};

  assign pop  = s_axi_rvalid && s_axi_rready;
  assign push = inflight_q;

  // Slots that will be occupied next cycle once the in-flight read lands;
  // issuing only below two guarantees the returning beat always has room.
  assign occ      = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = (state_q == RD) && (iss_left_q != 9'd0) && (occ < 3'd2);

  assign mem_we    = w_hs && !err_q;
  assign mem_re    = rd_issue && !err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = (state_q == WR) ? s_axi_wdata : '0;
  assign mem_be    = (state_q == WR) ? s_axi_wstrb : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_wr) state_d = WR;
               else if (grant_rd) state_d = RD;
      WR:      if (w_hs && (wlen_q == 8'd0)) state_d = WR_RESP;
      WR_RESP: if (s_axi_bready) state_d = IDLE;
      RD:      if (pop && s_axi_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= IDLE;
      en_q            <= 1'b0;
      last_rd_q       <= 1'b1;
      id_q            <= '0;
      wlen_q          <= '0;
      iss_left_q      <= '0;
      addr_q          <= '0;
      err_q           <= 1'b0;
      wl_err_q        <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      en_q            <= 1'b1;
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && (iss_left_q == 9'd1);
      if (grant_wr) begin
        last_rd_q <= 1'b0;
        id_q      <= s_axi_awid;
        wlen_q    <= s_axi_awlen;
        addr_q    <= aw_word;
        err_q     <= ERR_EN && over_end(aw_word, s_axi_awlen);
        wl_err_q  <= 1'b0;
      end else if (grant_rd) begin
        last_rd_q  <= 1'b1;
        id_q       <= s_axi_arid;
        iss_left_q <= {1'b0, s_axi_arlen} + 9'd1;
        addr_q     <= ar_word;
        err_q      <= ERR_EN && over_end(ar_word, s_axi_arlen);
        wl_err_q   <= 1'b0;
      end else if (w_hs) begin
        addr_q <= addr_q + MEM_AW'(1);
        if (wlen_q != 8'd0) wlen_q <= wlen_q - 8'd1;
        if (ERR_EN && (s_axi_wlast != (wlen_q == 8'd0))) wl_err_q <= 1'b1;
      end else if (rd_issue) begin
        addr_q     <= addr_q + MEM_AW'(1);
        iss_left_q <= iss_left_q - 9'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
        fifo_err[i]  <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr_q] <= err_q ? '0 : mem_rdata;
        fifo_last[wr_ptr_q] <= inflight_last_q;
        fifo_err[wr_ptr_q]  <= err_q;
        wr_ptr_q            <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: doc/cl_pcis_mem_bridge.md
# cl_pcis_mem_bridge

AXI4 slave that terminates the registered dma_pcis path. It sits directly downstream of the dma_pcis AXI register slice and consumes its master side. Incoming INCR write and read bursts are converted into single-beat accesses on a simple synchronous memory port, which feeds the PairHMM input/result buffers. Writes and reads share one memory port and are arbitrated per burst.

## Interface
Parameters:
- DATA_WIDTH, 512: AXI and memory data width.
- ID_WIDTH, 6: AXI ID width.
- MEM_AW, 10: memory word-address width (1024 words).
- ADDR_LSB, 6: log2(DATA_WIDTH/8); byte-address bits dropped to form the word address.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- s_axi  axi_if.slave  —  AXI4 slave.
  - Uses aw{id,addr,len,size,valid,ready}, w{data,strb,last,valid,ready}, b{id,resp,valid,ready}, ar{id,addr,len,size,valid,ready}, r{id,data,resp,last,valid,ready}.
  - awsize/arsize are ignored: every beat is a full DATA_WIDTH beat.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  DATA_WIDTH  write data (= wdata).
- mem_be  out  DATA_WIDTH/8  byte enables (= wstrb).
- mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after mem_re.

## Operation
- FSM states: IDLE, WR, WR_RESP, RD.
- IDLE: grants one address channel per burst.
  - Only awvalid pending: grant write.
  - Only arvalid pending: grant read.
  - Both pending: grant the opposite of the last granted burst type. last_grant resets to "read", so write wins the first tie.
  - Grant is signalled by awready or arready high in IDLE, combinationally from valid and last_grant.
  - On an AW handshake: latch id, len and word address awaddr[ADDR_LSB +: MEM_AW] into a beat counter and address counter; go to WR.
  - On an AR handshake: same capture from the AR channel; go to RD.
- WR:
  - wready = 1.
  - mem_we = wvalid & wready, mem_addr = address counter, wdata/wstrb passed through combinationally.
  - On each W handshake, the address counter increments modulo 2^MEM_AW.
  - The burst ends on beat awlen+1 regardless of wlast. Next state is WR_RESP.
- WR_RESP: bvalid = 1, bid = latched id, bresp per Configuration. On bready, go to IDLE.
- RD:
  - mem_re is issued while beats remain and (fifo_count + inflight − pop) < 2.
  - pop = rvalid & rready; inflight = mem_re of the previous cycle.
  - mem_rdata is written into a 2-entry output FIFO, together with a last flag set on beat arlen+1.
  - rvalid = FIFO not empty; rdata/rlast/rresp come from the FIFO head; rid = latched id.
  - State returns to IDLE on the pop of the last beat.
- mem_re and mem_we are never high in the same cycle.
- Reset value of every output is 0: awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast, mem_we, mem_re, mem_addr, mem_wdata, mem_be. Also FIFO empty, state IDLE, last_grant = read.
- Asserting aresetn low mid-burst aborts the burst immediately. No response is issued; outputs return to reset values asynchronously.

## Timing
- Write: AW handshake at cycle T → wready from T+1 → first mem_we at the first W handshake ≥ T+1 → bvalid the cycle after the last W handshake.
- Read: AR handshake at T → mem_re at T+1 → first rvalid at T+3.
  - With rready held high, one beat per cycle thereafter.
  - Burst of N beats: last beat at T+2+N.
- Back-to-back bursts: IDLE occupies one cycle between bursts, so awready/arready are high no earlier than the cycle after bready or the last R pop.
- Address wrap: word address 2^MEM_AW−1 followed by 0 within one burst; no error.
- rready low: FIFO fills to 2 and mem_re stalls. No beat is lost or duplicated.

## Configuration
- PCIS_BRIDGE_ERR_EN defined:
  - A burst whose start word + len exceeds 2^MEM_AW − 1 suppresses all mem_we/mem_re for that burst. It still consumes every W beat, or returns len+1 R beats with rdata = 0. Response is SLVERR (2'b10) in bresp/rresp.
  - A W burst whose wlast does not coincide with beat awlen+1 gets bresp = SLVERR, but its writes are still performed.
- Not defined: addresses always wrap, wlast is ignored, bresp/rresp are always OKAY (2'b00).

## Test plan
- Single write: awaddr=0x40, awlen=0, wdata=pattern A, wstrb all-ones → mem_we one cycle at mem_addr=1 with mem_be all-ones; bvalid one cycle later, bresp=0.
- 4-beat read: araddr=0x100, arlen=3, rready=1 → mem_addr 4,5,6,7 on consecutive cycles; rvalid at T+3..T+6; rlast only on the 4th beat; rid equals arid.
- Backpressure: 8-beat read with rready toggling 1010… → all 8 beats delivered in order, never more than 2 mem_re outstanding, no mem_re while the FIFO is full.
- Simultaneous AW and AR in the same cycle after reset → write granted first, read granted in the next IDLE; a repeat tie grants write again.
- Wrap/error: awaddr = (1023 words) × 64, awlen=1.
  - Without macro: writes to 1023 then 0, bresp=0.
  - With PCIS_BRIDGE_ERR_EN: no mem_we, bresp=2'b10.
- Reset mid-read: aresetn low during beat 2 of 4 → all outputs 0 immediately; after release, a new 1-beat read completes normally.
